// File: rtl/rtc_init_sequencer.sv
// RTC power-up init sequencer: walks the init decoder table and runs one
// multiplexed ALE/WR bus write per entry.
module rtc_init_sequencer #(
  parameter int N_REGS    = 5,
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] cuenta,
  output logic       a_d,
  output logic       en_n,
  output logic       c_s,
  output logic       cs_n,
  output logic       ale,
  output logic       wr_n,
  output logic       rd_n,
  output logic       bus_oe
);

  typedef enum logic [2:0] {
    IDLE, ADDR, AHOLD, DATA, RECOV, DONE
  } state_t;

  localparam logic [3:0] PH_LAST  = 4'(PHASE_CYC - 1);
  localparam logic [2:0] IDX_LAST = 3'(N_REGS - 1);

  state_t     state;
  state_t     nxt;
  logic [3:0] phase;
  logic       ph_end;
  logic       timed;

  // {busy, done, a_d, en_n, c_s, cs_n, ale, wr_n, bus_oe}
  function automatic logic [8:0] drive(input state_t s);
    case (s)
      ADDR:    return 9'b1_0_1_0_0_0_1_1_1;
      AHOLD:   return 9'b1_0_1_0_1_0_0_1_1;
      DATA:    return 9'b1_0_0_0_0_0_0_0_1;
      RECOV:   return 9'b1_0_0_0_1_1_0_1_0;
      DONE:    return 9'b0_1_1_1_0_1_0_1_0;
      default: return 9'b0_0_1_1_0_1_0_1_0;
    endcase
  endfunction

  assign ph_end = (phase == PH_LAST);
  assign timed  = (state == ADDR) || (state == DATA) ||
                  (state == RECOV);
  assign rd_n   = 1'b1;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = ADDR;
      ADDR:  if (ph_end) nxt = AHOLD;
      AHOLD: nxt = DATA;
      DATA:  if (ph_end) nxt = RECOV;
      RECOV:
        if (ph_end)
          nxt = (cuenta == IDX_LAST) ? DONE : ADDR;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are loaded with the value of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      phase  <= '0;
      cuenta <= '0;
      {busy, done, a_d, en_n, c_s, cs_n, ale, wr_n, bus_oe}
        <= drive(IDLE);
    end else begin
      state <= nxt;
      phase <= (timed && nxt == state) ? phase + 4'd1 : 4'd0;
      if (state == IDLE && start)
        cuenta <= '0;
      else if (state == RECOV && nxt == ADDR)
        cuenta <= cuenta + 3'd1;
      {busy, done, a_d, en_n, c_s, cs_n, ale, wr_n, bus_oe}
        <= drive(nxt);
    end
  end

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Bench for rtc_init_sequencer: default build plus a minimum-phase
// single-entry build, both checked every cycle against a timeline model.
module tb_rtc_init_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;

  logic       busy_a, done_a, a_d_a, en_n_a, c_s_a, cs_n_a;
  logic       ale_a, wr_n_a, rd_n_a, bus_oe_a;
  logic [2:0] cuenta_a;
  logic       busy_b, done_b, a_d_b, en_n_b, c_s_b, cs_n_b;
  logic       ale_b, wr_n_b, rd_n_b, bus_oe_b;
  logic [2:0] cuenta_b;

  always #5 clk = ~clk;

  rtc_init_sequencer #(.N_REGS(5), .PHASE_CYC(4)) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_a), .done(done_a), .cuenta(cuenta_a),
    .a_d(a_d_a), .en_n(en_n_a), .c_s(c_s_a), .cs_n(cs_n_a),
    .ale(ale_a), .wr_n(wr_n_a), .rd_n(rd_n_a), .bus_oe(bus_oe_a)
  );

  rtc_init_sequencer #(.N_REGS(1), .PHASE_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy_b), .done(done_b), .cuenta(cuenta_b),
    .a_d(a_d_b), .en_n(en_n_b), .c_s(c_s_b), .cs_n(cs_n_b),
    .ale(ale_b), .wr_n(wr_n_b), .rd_n(rd_n_b), .bus_oe(bus_oe_b)
  );

  logic [12:0] oa, ob;
  assign oa = {busy_a, done_a, cuenta_a, a_d_a, en_n_a, c_s_a,
               cs_n_a, ale_a, wr_n_a, rd_n_a, bus_oe_a};
  assign ob = {busy_b, done_b, cuenta_b, a_d_b, en_n_b, c_s_b,
               cs_n_b, ale_b, wr_n_b, rd_n_b, bus_oe_b};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: sequence is a timeline t = edges since the start was taken.
  int mp[2] = '{4, 2};
  int mn[2] = '{5, 1};
  bit mact[2] = '{1'b0, 1'b0};
  int mt[2] = '{0, 0};
  int mcue[2] = '{0, 0};

  int nbusy_a, ndone_a, nwr_a, ncs_a, nale_a;
  int nbusy_b, nwr_b, ndone_b;
  int done_q[$];
  logic [2:0] addr_cue;
  bit addr_stable;

  function automatic logic [12:0] ref_out(input int p, input int n,
      input bit act, input int t, input int cue);
    int l, e, r;
    l = n * (3 * p + 1);
    if (!act) return {2'b00, 3'(cue), 8'b1101_0110};
    if (t == l) return {2'b01, 3'(n - 1), 8'b1101_0110};
    e = t / (3 * p + 1);
    r = t % (3 * p + 1);
    if (r < p) return {2'b10, 3'(e), 8'b1000_1111};
    if (r == p) return {2'b10, 3'(e), 8'b1010_0111};
    if (r < 2 * p + 1) return {2'b10, 3'(e), 8'b0000_0011};
    return {2'b10, 3'(e), 8'b0011_0110};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int i);
    int l;
    l = mn[i] * (3 * mp[i] + 1);
    if (reset) begin
      mact[i] = 1'b0;
      mcue[i] = 0;
    end else if (mact[i]) begin
      mt[i]++;
      if (mt[i] > l) mact[i] = 1'b0;
      else if (mt[i] < l) mcue[i] = mt[i] / (3 * mp[i] + 1);
    end else if (start) begin
      mact[i] = 1'b1;
      mt[i] = 0;
      mcue[i] = 0;
    end
  endtask

  task automatic clr();
    nbusy_a = 0; ndone_a = 0; nwr_a = 0; ncs_a = 0; nale_a = 0;
    nbusy_b = 0; nwr_b = 0; ndone_b = 0;
    done_q.delete();
  endtask

  task automatic cycle();
    @(posedge clk);
    step(0);
    step(1);
    cyc++;
    #1;
    chk("dut_a_outputs", 32'(oa),
        32'(ref_out(mp[0], mn[0], mact[0], mt[0], mcue[0])));
    chk("dut_b_outputs", 32'(ob),
        32'(ref_out(mp[1], mn[1], mact[1], mt[1], mcue[1])));
    if (busy_a) nbusy_a++;
    if (done_a) begin ndone_a++; done_q.push_back(cyc); end
    if (!wr_n_a) nwr_a++;
    if (!cs_n_a) ncs_a++;
    if (ale_a) nale_a++;
    if (busy_b) nbusy_b++;
    if (!wr_n_b) nwr_b++;
    if (done_b) ndone_b++;
    // address byte must not move while ALE is high on the short build
    if (ale_b && addr_cue !== cuenta_b) addr_stable = 1'b0;
    if (ale_b) addr_cue = cuenta_b;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int c0;
    addr_cue = 3'd0;
    addr_stable = 1'b1;
    clr();
    run(3);
    chk("reset_busy_never", 32'(nbusy_a + nbusy_b), 32'd0);
    chk("reset_vals_a", 32'(oa), 32'h0D6);
    reset = 1'b0;
    start = 1'b0;
    run(3);

    // Nominal single-pulse run
    clr();
    start = 1'b1;
    cycle();
    c0 = cyc;
    start = 1'b0;
    run(75);
    chk("nom_busy_len", 32'(nbusy_a), 32'd65);
    chk("nom_done_cnt", 32'(ndone_a), 32'd1);
    if (done_q.size() > 0)
      chk("nom_done_edge", 32'(done_q[0] - c0), 32'd65);
    chk("nom_wr_low", 32'(nwr_a), 32'd20);
    chk("nom_cs_low", 32'(ncs_a), 32'd45);
    chk("nom_ale_high", 32'(nale_a), 32'd20);
    chk("nom_end_cuenta", 32'(cuenta_a), 32'd4);
    chk("min_busy_len", 32'(nbusy_b), 32'd7);
    chk("min_wr_low", 32'(nwr_b), 32'd2);
    chk("min_done_cnt", 32'(ndone_b), 32'd1);
    chk("min_addr_stable", 32'(addr_stable), 32'd1);

    // Start pulse during a running sequence is dropped
    clr();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(19);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(60);
    chk("ign_busy_len", 32'(nbusy_a), 32'd65);
    chk("ign_done_cnt", 32'(ndone_a), 32'd1);

    // Reset while entry 2 is in its data phase
    clr();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(32);
    chk("mid_in_data_wr", 32'(wr_n_a), 32'd0);
    chk("mid_in_data_idx", 32'(cuenta_a), 32'd2);
    reset = 1'b1;
    cycle();
    chk("mid_abort", 32'({wr_n_a, cs_n_a, bus_oe_a, busy_a,
        done_a, cuenta_a}), 32'b1_1_0_0_0_000);
    reset = 1'b0;
    run(2);
    chk("mid_no_done", 32'(ndone_a), 32'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("replay_idx", 32'(cuenta_a), 32'd0);
    chk("replay_ale", 32'(ale_a), 32'd1);
    run(70);

    // Start held: back-to-back sequences
    clr();
    start = 1'b1;
    run(205);
    start = 1'b0;
    chk("cont_done_cnt", 32'(done_q.size()), 32'd3);
    if (done_q.size() >= 3) begin
      chk("cont_gap1", 32'(done_q[1] - done_q[0]), 32'd67);
      chk("cont_gap2", 32'(done_q[2] - done_q[1]), 32'd67);
    end
    run(70);

    // Random start/reset traffic against the model
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(7) == 0);
      reset = ($urandom_range(149) == 0);
      cycle();
    end
    reset = 1'b0;
    start = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtc_init_sequencer.md
# rtc_init_sequencer

Sequencer that drives the RTC power-up initialization. It steps the initialization decoder through its register table (index 0..N_REGS-1). For each entry it runs one multiplexed address/data bus write cycle: an address phase with ALE, then a data phase with WR. It sits between the top-level control FSM, which issues `start` and consumes `done`, and the initialization decoder plus the RTC AD-bus drivers.

## Interface
- `N_REGS`, 5: number of table entries to write; legal 1..5.
- `PHASE_CYC`, 4: clk cycles per address, data and recovery phase; legal 2..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a full init sequence; sampled only in IDLE.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse after the last entry completes.
- `cuenta`  out  3  decoder table index.
- `a_d`  out  1  decoder select: 1 = address byte, 0 = data byte.
- `en_n`  out  1  decoder enable, active-low; 1 forces decoder output to 8'hFF.
- `c_s`  out  1  decoder hold; 1 freezes decoder output.
- `cs_n`  out  1  RTC chip select, active-low.
- `ale`  out  1  RTC address latch enable, active-high.
- `wr_n`  out  1  RTC write strobe, active-low.
- `rd_n`  out  1  RTC read strobe; constant 1 (write-only block).
- `bus_oe`  out  1  AD-bus output enable toward the RTC.

## Operation
- States: IDLE, ADDR, AHOLD, DATA, RECOV, DONE.
- Phase counter: 4 bits. It loads 0 on every state entry, counts up, and exits at `PHASE_CYC-1`. AHOLD and DONE each last exactly 1 cycle.
- IDLE to ADDR when `start`=1. `cuenta` loads 0.
- ADDR: `a_d`=1, `en_n`=0, `c_s`=0, `cs_n`=0, `ale`=1, `bus_oe`=1. Next state AHOLD.
- AHOLD: `ale`=0, `c_s`=1. The address byte stays frozen on the bus while ALE falls. Next state DATA.
- DATA: `a_d`=0, `c_s`=0, `wr_n`=0, `cs_n`=0, `bus_oe`=1. Next state RECOV.
- RECOV: `wr_n`=1, `cs_n`=1, `c_s`=1, `bus_oe`=0.
  - If `cuenta`=N_REGS-1: next state DONE.
  - Otherwise: `cuenta` increments and the next state is ADDR.
- DONE: `done`=1 and `en_n`=1. Next state IDLE. `cuenta` is held until the next start.
- `busy`=1 in every state except IDLE and DONE.
- `start` outside IDLE is ignored. It is not queued.
- The decoder updates its output on both clock edges. ADDR and DATA hold `a_d`/`cuenta` for ≥2 full cycles, so the byte is stable at least 1 cycle before `ale` falls and before `wr_n` rises.
- Reset:
  - Outputs take these values on the first rising edge with `reset`=1 and hold them while `reset`=1: `busy`=0, `done`=0, `cuenta`=0, `a_d`=1, `en_n`=1, `c_s`=0, `cs_n`=1, `ale`=0, `wr_n`=1, `rd_n`=1, `bus_oe`=0, state IDLE, phase counter 0.
  - Reset mid-cycle aborts the cycle immediately. No partial strobe may survive past that edge.
- All outputs are registered. None is a combinational function of `start`.

## Timing
- Start latency: `start` sampled high in IDLE at edge k puts the FSM in ADDR after edge k. `busy`, `cs_n`=0 and `ale`=1 are all visible from edge k+1.
- Per entry: 3·PHASE_CYC+1 cycles (ADDR P, AHOLD 1, DATA P, RECOV P).
- Full sequence: `busy` high for N_REGS·(3·PHASE_CYC+1) cycles. Defaults give 65 cycles.
- `done` is high for the single cycle after the last RECOV. IDLE is reached the next cycle.
- Earliest restart: `start` held continuously gives back-to-back sequences with exactly 2 non-busy cycles between them (DONE, IDLE).
- `ale` falls 1 cycle before DATA begins. `wr_n` is low for exactly PHASE_CYC cycles per entry. `cs_n` is low for 2·PHASE_CYC+1 cycles per entry.

## Test plan
- Reset values: assert `reset` for 3 cycles with `start`=1 → every output at its listed reset value and `busy` never rises. Release reset → sequence begins on the next `start` sample.
- Nominal run, defaults: 1-cycle `start` pulse →
  - `busy` high for 65 cycles and `cuenta` steps 0,1,2,3,4.
  - Per entry: `ale` high 4 cycles, `wr_n` low 4 cycles, `cs_n` low 9 cycles.
  - `done` pulses once at cycle 66 after `start`.
- Ignored start: pulse `start` at cycle 20 of a running sequence → total `busy` length unchanged (65) and exactly one `done`.
- Reset mid-operation: assert `reset` during DATA of `cuenta`=2 → the next edge shows `wr_n`=1, `cs_n`=1, `bus_oe`=0, `cuenta`=0, `busy`=0 and no `done`. A new `start` replays from entry 0.
- Minimum phase: `PHASE_CYC`=2, `N_REGS`=1 → `busy` high 7 cycles, `wr_n` low 2 cycles, decoder output stable on the bus ≥1 cycle before `ale` falls.
- Continuous start: hold `start`=1 for 3 sequences → 3 `done` pulses spaced 67 cycles apart (defaults) and `cuenta` returns to 0 each time.
